// File: rtl/cmd_proc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmd_proc_pkg
// Description : Shared opcode/state encodings, counter sizing and a
//               saturating-increment helper for the cmd_proc block.
// Revision    : 1.0 - initial release
// ============================================================================
package cmd_proc_pkg;

    // Command opcodes; encodings 6..15 are illegal
    typedef enum logic [3:0] {
        NOP   = 4'd0,
        WRITE = 4'd1,
        READ  = 4'd2,
        INC   = 4'd3,
        CLEAR = 4'd4,
        FILL  = 4'd5
    } cmd_e;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = 255;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    // Counter increment that holds at the maximum instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_W'(CNT_MAX)) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_proc_regfile.sv
`default_nettype none
// ============================================================================
// Module      : cmd_proc_regfile
// Description : DEPTH x DW flop register file. One write port that can
//               either load data or increment the addressed entry, and one
//               registered read port with a forwarding override.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_proc_regfile #(
    parameter int AW = 4,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic          inc,
    input  logic [AW-1:0] wadr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] radr,
    input  logic          fwd_en,
    input  logic [DW-1:0] fwd_data,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = 2**AW;

    logic [DW-1:0] mem [DEPTH];

    // Storage: load or read-modify-write increment on the single write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wadr] <= inc ? (mem[wadr] + DW'(1)) : wdata;
        end
    end

    // Registered read; the forward path substitutes data not yet in storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= fwd_en ? fwd_data : mem[radr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/cmd_proc.sv
`default_nettype none
// ============================================================================
// Module      : cmd_proc
// Description : Bus-slave command processor. Executes one 4-bit command per
//               clock against a 2**AW x DW register file; CLEAR/FILL run a
//               multi-cycle sweep with busy asserted. Counts illegal opcodes
//               and commands dropped while busy (both saturating).
//               Optional macro CMD_PROC_RD_BYPASS_EN: read-after-write
//               bypass register, and a READ in the final sweep cycle is
//               accepted and answered with the sweep value.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_proc
    import cmd_proc_pkg::*;
#(
    parameter int            AW      = 4,
    parameter int            DW      = 4,
    parameter logic [DW-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       cmd,
    input  logic [AW-1:0]    adr,
    input  logic [DW-1:0]    data,
    output logic             busy,
    output logic             rd_valid,
    output logic [DW-1:0]    rd_data,
    output logic [AW-1:0]    rd_adr,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int DEPTH = 2**AW;

    state_e        state;
    state_e        state_nxt;
    logic [AW-1:0] idx;
    logic [DW-1:0] sweep_val;

    logic          in_idle;
    logic          in_sweep;
    logic          last_sweep;
    logic          is_write;
    logic          is_read;
    logic          is_inc;
    logic          is_sweep_cmd;
    logic          is_illegal;
    logic          rd_late;
    logic          rd_accept;
    logic          drop;
    logic          fwd_en;
    logic [DW-1:0] fwd_data;

    assign in_idle    = (state == IDLE);
    assign in_sweep   = (state == SWEEP);
    assign last_sweep = in_sweep && (idx == AW'(DEPTH-1));

    // Opcode decode; everything here only acts while idle
    always_comb begin
        is_write     = 1'b0;
        is_read      = 1'b0;
        is_inc       = 1'b0;
        is_sweep_cmd = 1'b0;
        is_illegal   = 1'b0;
        case (cmd)
            NOP:          ;
            WRITE:        is_write     = in_idle;
            READ:         is_read      = in_idle;
            INC:          is_inc       = in_idle;
            CLEAR, FILL:  is_sweep_cmd = in_idle;
            default:      is_illegal   = in_idle;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: a sweep ends after writing the last entry
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (is_sweep_cmd) state_nxt = SWEEP;
            SWEEP:   if (last_sweep)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state == SWEEP);
    end

    // Sweep value latch and entry index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            sweep_val <= '0;
        end else if (is_sweep_cmd) begin
            idx       <= '0;
            sweep_val <= (cmd == FILL) ? data : CLR_VAL;
        end else if (in_sweep) begin
            idx       <= idx + AW'(1);
        end
    end

`ifdef CMD_PROC_RD_BYPASS_EN
    logic          byp_valid;
    logic [AW-1:0] byp_adr;
    logic [DW-1:0] byp_data;
    logic          byp_hit;

    // Capture the most recent WRITE so a following READ can skip storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_valid <= 1'b0;
            byp_adr   <= '0;
            byp_data  <= '0;
        end else begin
            byp_valid <= is_write;
            if (is_write) begin
                byp_adr  <= adr;
                byp_data <= data;
            end
        end
    end

    // In the final sweep cycle every entry already holds (or is receiving)
    // the sweep value, so a READ can be answered from sweep_val directly.
    assign rd_late  = last_sweep && (cmd == READ);
    assign byp_hit  = is_read && byp_valid && (byp_adr == adr);
    assign fwd_en   = byp_hit || rd_late;
    assign fwd_data = rd_late ? sweep_val : byp_data;
`else
    assign rd_late  = 1'b0;
    assign fwd_en   = 1'b0;
    assign fwd_data = sweep_val;
`endif

    assign rd_accept = is_read || rd_late;
    assign drop      = in_sweep && (cmd != NOP) && !rd_late;

    cmd_proc_regfile #(
        .AW (AW),
        .DW (DW)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (is_write || is_inc || in_sweep),
        .inc      (is_inc),
        .wadr     (in_sweep ? idx : adr),
        .wdata    (in_sweep ? sweep_val : data),
        .re       (rd_accept),
        .radr     (adr),
        .fwd_en   (fwd_en),
        .fwd_data (fwd_data),
        .rdata    (rd_data)
    );

    // Read response qualifier and address, aligned with rd_data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_adr   <= '0;
        end else begin
            rd_valid <= rd_accept;
            if (rd_accept) begin
                rd_adr <= adr;
            end
        end
    end

    // Saturating error and drop counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (is_illegal) err_cnt  <= sat_inc(err_cnt);
            if (drop)       drop_cnt <= sat_inc(drop_cnt);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmd_proc.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmd_proc
// Description : Directed self-checking bench for cmd_proc.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_proc;
    import cmd_proc_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] cmd;
    logic [3:0] adr;
    logic [3:0] data;
    logic       busy;
    logic       rd_valid;
    logic [3:0] rd_data;
    logic [3:0] rd_adr;
    logic [7:0] err_cnt;
    logic [7:0] drop_cnt;

    int errors = 0;
    int checks = 0;

    cmd_proc dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd      (cmd),
        .adr      (adr),
        .data     (data),
        .busy     (busy),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_adr   (rd_adr),
        .err_cnt  (err_cnt),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one command; returns 1 time unit after the edge that sampled it
    task automatic send(input logic [3:0] c, input logic [3:0] a, input logic [3:0] d);
        cmd  = c;
        adr  = a;
        data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [3:0] a, input logic [3:0] exp, input string tag);
        send(READ, a, 4'h0);
        check({tag, "_valid"}, rd_valid, 1'b1);
        check({tag, "_data"},  rd_data,  exp);
        check({tag, "_adr"},   rd_adr,   a);
    endtask

    // Step through a sweep already started; optionally issue a READ at the
    // read_at-th busy cycle and capture the response seen one cycle later.
    task automatic run_sweep(input int read_at, input logic [3:0] radr, output int bc,
                             output logic rv, output logic [3:0] rdd, output logic [3:0] rda);
        bc  = 0;
        rv  = 1'b0;
        rdd = 4'h0;
        rda = 4'h0;
        while (busy && bc < 100) begin
            bc++;
            if (bc == read_at) begin
                send(READ, radr, 4'h0);
                rv  = rd_valid;
                rdd = rd_data;
                rda = rd_adr;
            end else begin
                send(NOP, 4'h0, 4'h0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         bc;
        logic       rv;
        logic [3:0] rdd;
        logic [3:0] rda;

        rst_n = 1'b0;
        cmd   = NOP;
        adr   = 4'h0;
        data  = 4'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_busy",  busy,     1'b0);
        check("rst_valid", rd_valid, 1'b0);
        check("rst_data",  rd_data,  4'h0);
        check("rst_adr",   rd_adr,   4'h0);
        check("rst_err",   err_cnt,  8'd0);
        check("rst_drop",  drop_cnt, 8'd0);
        rst_n = 1'b1;

        // Write then read-after-write
        send(WRITE, 4'd3, 4'd9);
        do_read(4'd3, 4'd9, "raw3");
        send(NOP, 4'h0, 4'h0);
        check("rd_pulse", rd_valid, 1'b0);

        // Increment wrap and repeated increment
        send(WRITE, 4'd7, 4'd15);
        send(INC, 4'd7, 4'h0);
        do_read(4'd7, 4'd0, "inc_wrap");
        send(INC, 4'd2, 4'h0);
        send(INC, 4'd2, 4'h0);
        send(INC, 4'd2, 4'h0);
        do_read(4'd2, 4'd3, "inc3");

        // FILL 5 with a dropped READ at the 4th busy cycle
        send(FILL, 4'h0, 4'd5);
        check("fill_busy_n1", busy, 1'b1);
        run_sweep(4, 4'd1, bc, rv, rdd, rda);
        check("fill_busy_len", bc, 16);
        check("fill_drop_rv", rv, 1'b0);
        check("fill_drop_cnt", drop_cnt, 8'd1);
        for (int i = 0; i < 16; i++) begin
            do_read(4'(i), 4'd5, $sformatf("fill5_%0d", i));
        end

        // CLEAR returns all entries to zero
        send(CLEAR, 4'h0, 4'hF);
        run_sweep(0, 4'h0, bc, rv, rdd, rda);
        check("clr_busy_len", bc, 16);
        for (int i = 0; i < 16; i++) begin
            do_read(4'(i), 4'd0, $sformatf("clr_%0d", i));
        end

        // Illegal opcodes saturate err_cnt, leave drop_cnt alone
        for (int i = 0; i < 300; i++) begin
            send(4'd9, 4'h0, 4'h0);
        end
        send(NOP, 4'h0, 4'h0);
        check("err_sat", err_cnt, 8'd255);
        check("err_drop_hold", drop_cnt, 8'd1);

        // Reset in the middle of a FILL (index 8)
        send(FILL, 4'h0, 4'hA);
        for (int i = 0; i < 8; i++) begin
            send(NOP, 4'h0, 4'h0);
        end
        check("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_err",  err_cnt, 8'd0);
        check("mid_rst_drop", drop_cnt, 8'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("post_rst_busy", busy, 1'b0);
        for (int i = 0; i < 16; i++) begin
            do_read(4'(i), 4'd0, $sformatf("mid_%0d", i));
        end
        check("post_rst_err",  err_cnt, 8'd0);
        check("post_rst_drop", drop_cnt, 8'd0);

        // READ in the final sweep cycle of FILL 6
        send(FILL, 4'h0, 4'd6);
        run_sweep(16, 4'd15, bc, rv, rdd, rda);
        check("last_busy_len", bc, 16);
`ifdef CMD_PROC_RD_BYPASS_EN
        check("last_rd_valid", rv, 1'b1);
        check("last_rd_data", rdd, 4'd6);
        check("last_rd_adr", rda, 4'd15);
        check("last_drop", drop_cnt, 8'd0);
`else
        check("last_rd_valid", rv, 1'b0);
        check("last_drop", drop_cnt, 8'd1);
`endif
        check("last_busy_low", busy, 1'b0);
        do_read(4'd15, 4'd6, "last15");
        do_read(4'd0, 4'd6, "last0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cmd_proc.md
Name: cmd_proc

Overview:
- Downstream consumer of the DUT bus interface: attaches to the slave side (clk, cmd, adr, data) and executes one 4-bit command per clock.
- Holds a 16-entry x 4-bit register file with single-cycle write, read and increment commands.
- Multi-cycle CLEAR and FILL sweeps assert busy.
- Acts as the concrete DUT whose cmd/adr traffic the covergroups on the interface observe.

Parameters:
- AW, 4, address width; DEPTH = 2**AW entries.
- DW, 4, data width.
- CLR_VAL, 4'h0, value written by CLEAR.

Ports:
- clk  input  1  bus clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd  input  4  command opcode, sampled every rising edge.
- adr  input  AW  entry address.
- data  input  DW  write/fill data.
- busy  output  1  sweep in progress; commands are not accepted.
- rd_valid  output  1  rd_data/rd_adr valid this cycle.
- rd_data  output  DW  read result.
- rd_adr  output  AW  address of the read result.
- err_cnt  output  8  count of illegal opcodes, saturating.
- drop_cnt  output  8  count of non-NOP commands dropped while busy, saturating.

Behaviour:
- Reset (async assert, sync release):
  - busy=0, rd_valid=0, rd_data=0, rd_adr=0, err_cnt=0, drop_cnt=0.
  - All register-file entries = 0.
  - FSM = IDLE, sweep index = 0.
- Opcodes: 0 NOP, 1 WRITE, 2 READ, 3 INC, 4 CLEAR, 5 FILL, 6-15 illegal.
- FSM states: IDLE, SWEEP.
- IDLE, command sampled at edge N:
  - WRITE: mem[adr] <= data at edge N.
  - READ: rd_valid=1, rd_data=mem[adr], rd_adr=adr during cycle N+1 (latency 1, registered). rd_valid is a one-cycle pulse per READ.
  - INC: mem[adr] <= mem[adr]+1, modulo 2**DW (15 wraps to 0). No response.
  - CLEAR/FILL: latch the sweep value (CLR_VAL, or data for FILL), move to SWEEP, index=0. busy=1 from cycle N+1.
  - Illegal opcode: err_cnt += 1 (saturates at 255). No state change.
  - NOP: no effect.
- SWEEP: each cycle writes the sweep value to mem[index] and increments index.
  - After writing index DEPTH-1, return to IDLE; busy=0 on the following cycle.
  - busy is high for exactly DEPTH cycles.
- During busy, every non-NOP command (including illegal opcodes) is dropped and counted: drop_cnt += 1, saturating. err_cnt is not touched.
- Hazards:
  - WRITE at N followed by READ of the same adr at N+1 returns the new data.
  - INC at N followed by READ at N+1 returns the incremented value.
- Reset asserted mid-sweep: immediate return to IDLE with all entries 0. No partial-sweep state survives.
- Counters hold at 255 and never wrap.

Optional Feature:
- Macro: CMD_PROC_RD_BYPASS_EN.
- Defined: READ in IDLE to the same adr as a WRITE sampled in the immediately preceding cycle is satisfied from a bypass register. Visible results are identical to the undefined case.
- Defined, additional rule: READ sampled in the same cycle that a sweep completes (the last SWEEP cycle, busy still 1) is accepted, not dropped, and returns the sweep value. This shortens the blocked window to DEPTH-1 cycles.
- Undefined: a READ in the last SWEEP cycle is dropped and counted in drop_cnt.

Decomposition:
- Package cmd_proc_pkg holds:
  - enum cmd_e (NOP=0 .. FILL=5);
  - localparam CNT_W=8 and CNT_MAX=255;
  - typedef state_e {IDLE, SWEEP}.
- Sub-module cmd_proc_regfile: DEPTH x DW flops with async clear, one write port, one registered read port. The top holds the FSM, decode and counters.

Test Plan:
- Reset, then WRITE adr=3 data=9, then READ adr=3 next cycle -> rd_valid pulse one cycle later, rd_data=9, rd_adr=3.
- WRITE adr=7 data=15, INC adr=7, READ adr=7 -> rd_data=0 (wrap). INC ×3 on adr=2 from 0, READ -> 3.
- FILL data=5 at N -> busy high for exactly 16 cycles from N+1. READ issued at N+4 -> no rd_valid, drop_cnt=1. READs of adr 0..15 after busy falls -> all 5.
- CLEAR after FILL -> all entries 0. Illegal opcode 9 sent 300 times in IDLE -> err_cnt=255, drop_cnt unchanged.
- Assert rst_n low at sweep index 8 of a FILL data=A -> busy=0 immediately, all reads return 0 after release, counters 0.
- With CMD_PROC_RD_BYPASS_EN: READ adr=15 in the last SWEEP cycle of FILL data=6 -> rd_data=6, drop_cnt unchanged. Without the macro: dropped, drop_cnt +1.
